// File: rtl/ad_pkg.sv
// Shared types and constants for the ADC averaging filter.
package ad_pkg;

  localparam int ADC_W     = 10;
  localparam int LOG2N_DEF = 3;

  typedef logic [ADC_W-1:0] adc_sample_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UPD  = 2'd1,
    OUT  = 2'd2
  } ad_state_e;

endpackage

// File: rtl/ad_avg_chan.sv
// One channel of the moving-average filter: circular sample buffer,
// running sum, fill counter and the registered average/primed outputs.
import ad_pkg::*;

module ad_avg_chan #(
  parameter int LOG2N = LOG2N_DEF,
  parameter int ADC_W = ad_pkg::ADC_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_upd_en,
  input  logic             i_out_en,
  input  logic [ADC_W-1:0] i_smp,
  output logic [ADC_W-1:0] o_avg,
  output logic             o_primed
);

  localparam int DEPTH = 2**LOG2N;
  localparam int SUM_W = ADC_W + LOG2N;
  localparam logic [LOG2N:0] FULL = (LOG2N+1)'(DEPTH);

  logic [ADC_W-1:0] r_buf [DEPTH];
  logic [LOG2N-1:0] r_ptr;
  logic [LOG2N:0]   r_fill;
  logic [SUM_W-1:0] r_sum;
  logic [ADC_W-1:0] r_avg;
  logic             r_primed;

  logic [ADC_W-1:0] w_old;
  logic [SUM_W-1:0] w_sum_nxt;

  // The oldest sample is replaced in place, so the running sum swaps it out
  // in one step; the sum of DEPTH full-scale samples still fits in SUM_W.
  always_comb begin
    w_old     = r_buf[r_ptr];
    w_sum_nxt = r_sum + SUM_W'(i_smp) - SUM_W'(w_old);
  end

  // Buffer write, pointer advance, running sum and saturating fill count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_buf[i] <= '0;
      end
      r_ptr  <= '0;
      r_fill <= '0;
      r_sum  <= '0;
    end else if (i_upd_en) begin
      r_buf[r_ptr] <= i_smp;
      r_sum        <= w_sum_nxt;
      r_ptr        <= r_ptr + 1'b1;
      if (r_fill != FULL) begin
        r_fill <= r_fill + 1'b1;
      end
    end
  end

  // Publish floor(sum / DEPTH); primed is sticky once the window is full.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_avg    <= '0;
      r_primed <= 1'b0;
    end else if (i_out_en) begin
      r_avg <= r_sum[SUM_W-1:LOG2N];
      if (r_fill == FULL) begin
        r_primed <= 1'b1;
      end
    end
  end

  assign o_avg    = r_avg;
  assign o_primed = r_primed;

endmodule

// File: rtl/ad_avg_filter.sv
// Captures finished ADC samples on the rising edge of CSLD and maintains
// an independent moving average for the left and right channels.
import ad_pkg::*;

module ad_avg_filter #(
  parameter int LOG2N = LOG2N_DEF,
  parameter int ADC_W = ad_pkg::ADC_W
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CSLD,
  input  logic             right,
  input  logic [ADC_W-1:0] num,
  output logic [ADC_W-1:0] avg_l,
  output logic [ADC_W-1:0] avg_r,
  output logic             avg_valid,
  output logic             avg_ch,
  output logic             primed_l,
  output logic             primed_r,
  output logic             overrun
);

  ad_state_e        r_state;
  ad_state_e        w_state_nxt;
  logic             r_csld_q;
  logic [ADC_W-1:0] r_smp;
  logic             r_ch;
  logic             r_avg_valid;
  logic             r_avg_ch;
  logic             r_overrun;

  logic             w_edge;
  logic             w_capture;
  logic             w_upd_l;
  logic             w_upd_r;
  logic             w_out_l;
  logic             w_out_r;

  // csld_q resets high so a CSLD already high at reset release is no edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_csld_q <= 1'b1;
    end else begin
      r_csld_q <= CSLD;
    end
  end

  assign w_edge = CSLD & ~r_csld_q;

  // FSM state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and per-channel strobes: IDLE waits for an edge, UPD and OUT
  // last one cycle each and ignore further edges.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_upd_l     = 1'b0;
    w_upd_r     = 1'b0;
    w_out_l     = 1'b0;
    w_out_r     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_edge) begin
          w_capture   = 1'b1;
          w_state_nxt = UPD;
        end
      end
      UPD: begin
        w_upd_l     = ~r_ch;
        w_upd_r     = r_ch;
        w_state_nxt = OUT;
      end
      OUT: begin
        w_out_l     = ~r_ch;
        w_out_r     = r_ch;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Latch the finished sample and its channel when the edge is accepted.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_smp <= '0;
      r_ch  <= 1'b0;
    end else if (w_capture) begin
      r_smp <= num;
      r_ch  <= right;
    end
  end

  // Valid strobe and channel tag register together with the new average.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_avg_valid <= 1'b0;
      r_avg_ch    <= 1'b0;
    end else begin
      r_avg_valid <= (r_state == OUT);
      if (r_state == OUT) begin
        r_avg_ch <= r_ch;
      end
    end
  end

  // Sticky fault flag: an edge arrived while a sample was still in flight.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_overrun <= 1'b0;
    end else if (w_edge && (r_state != IDLE)) begin
      r_overrun <= 1'b1;
    end
  end

  ad_avg_chan #(
    .LOG2N (LOG2N),
    .ADC_W (ADC_W)
  ) u_chan_l (
    .i_clk    (CLK),
    .i_rst_n  (RST_N),
    .i_upd_en (w_upd_l),
    .i_out_en (w_out_l),
    .i_smp    (r_smp),
    .o_avg    (avg_l),
    .o_primed (primed_l)
  );

  ad_avg_chan #(
    .LOG2N (LOG2N),
    .ADC_W (ADC_W)
  ) u_chan_r (
    .i_clk    (CLK),
    .i_rst_n  (RST_N),
    .i_upd_en (w_upd_r),
    .i_out_en (w_out_r),
    .i_smp    (r_smp),
    .o_avg    (avg_r),
    .o_primed (primed_r)
  );

  assign avg_valid = r_avg_valid;
  assign avg_ch    = r_avg_ch;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_ad_avg_filter.sv
// Scoreboard bench for ad_avg_filter: a driver issues ADC frames and
// queues expected results from a sample-history model; a monitor checks
// every avg_valid strobe against the queue, including its timing.
module tb_ad_avg_filter;

  localparam int W     = 10;
  localparam int DEPTH = 8;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic         CSLD;
  logic         right;
  logic [W-1:0] num;
  logic [W-1:0] avg_l;
  logic [W-1:0] avg_r;
  logic         avg_valid;
  logic         avg_ch;
  logic         primed_l;
  logic         primed_r;
  logic         overrun;

  ad_avg_filter #(.LOG2N(3), .ADC_W(W)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .CSLD      (CSLD),
    .right     (right),
    .num       (num),
    .avg_l     (avg_l),
    .avg_r     (avg_r),
    .avg_valid (avg_valid),
    .avg_ch    (avg_ch),
    .primed_l  (primed_l),
    .primed_r  (primed_r),
    .overrun   (overrun)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    bit ch;
    int al;
    int ar;
    bit pl;
    bit pr;
    int due;
  } exp_t;

  exp_t sb[$];
  int   hist_l[$];
  int   hist_r[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Average over the most recent DEPTH samples, missing ones counting as 0.
  function automatic int window_avg(input int q[$]);
    int s = 0;
    foreach (q[i]) s += q[i];
    return s / DEPTH;
  endfunction

  task automatic model_push(input bit ch, input int val, input int due);
    exp_t e;
    if (ch) begin
      hist_r.push_front(val);
      if (hist_r.size() > DEPTH) void'(hist_r.pop_back());
    end else begin
      hist_l.push_front(val);
      if (hist_l.size() > DEPTH) void'(hist_l.pop_back());
    end
    e.ch  = ch;
    e.al  = window_avg(hist_l);
    e.ar  = window_avg(hist_r);
    e.pl  = (hist_l.size() == DEPTH);
    e.pr  = (hist_r.size() == DEPTH);
    e.due = due;
    sb.push_back(e);
  endtask

  // Monitor: every strobe must match the oldest queued expectation.
  always @(negedge CLK) begin
    if (RST_N && avg_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got avg_valid=1 at cycle %0d expected no strobe", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (avg_ch !== e.ch || avg_l !== W'(e.al) || avg_r !== W'(e.ar) ||
            primed_l !== e.pl || primed_r !== e.pr) begin
          failures++;
          $display("FAIL result: got ch=%0d l=%0d r=%0d pl=%0d pr=%0d expected ch=%0d l=%0d r=%0d pl=%0d pr=%0d",
                   avg_ch, avg_l, avg_r, primed_l, primed_r, e.ch, e.al, e.ar, e.pl, e.pr);
        end
        checks++;
        if (cyc != e.due) begin
          failures++;
          $display("FAIL latency: got valid at cycle %0d expected cycle %0d", cyc, e.due);
        end
      end
    end
  end

  // One upstream frame: CSLD low while the sample is presented, then a
  // rising edge held high long enough for the result to come out.
  task automatic send(input bit ch, input int val);
    @(negedge CLK);
    CSLD  = 1'b0;
    num   = W'(val);
    right = ch;
    repeat (3) @(negedge CLK);
    CSLD = 1'b1;
    model_push(ch, val, cyc + 3);
    repeat (5) @(negedge CLK);
  endtask

  initial begin
    RST_N = 1'b0;
    CSLD  = 1'b1;
    right = 1'b0;
    num   = '0;

    // Reset state, with CSLD held high across release
    repeat (3) @(negedge CLK);
    chk("reset_outputs", {avg_l, avg_r, avg_valid, avg_ch, primed_l, primed_r, overrun}, 0);
    RST_N = 1'b1;
    repeat (5) @(negedge CLK);
    chk("no_valid_after_release", avg_valid, 0);

    // Eight left samples of 100
    for (int i = 0; i < 8; i++) send(1'b0, 100);
    chk("t2_avg_l", avg_l, 100);
    chk("t2_primed_l", primed_l, 1);
    chk("t2_avg_r", avg_r, 0);
    chk("t2_primed_r", primed_r, 0);

    // Interleaved full-scale left and zero right
    for (int i = 0; i < 8; i++) begin
      send(1'b0, 1023);
      send(1'b1, 0);
    end
    chk("t3_avg_l", avg_l, 1023);
    chk("t3_avg_r", avg_r, 0);

    // Step response from a primed window of 100
    for (int i = 0; i < 8; i++) send(1'b0, 100);
    send(1'b0, 900);
    chk("t4_avg_l_step", avg_l, 200);
    for (int i = 0; i < 16; i++) send(1'b0, 500);
    chk("t4_avg_l_wrap", avg_l, 500);
    chk("overrun_clear", overrun, 0);

    // Second edge two cycles after the first lands in OUT and is dropped
    @(negedge CLK);
    CSLD  = 1'b0;
    num   = W'(300);
    right = 1'b0;
    repeat (3) @(negedge CLK);
    CSLD = 1'b1;
    model_push(1'b0, 300, cyc + 3);
    @(negedge CLK);
    CSLD = 1'b0;
    num  = W'(700);
    @(negedge CLK);
    CSLD = 1'b1;
    repeat (6) @(negedge CLK);
    chk("t5_overrun", overrun, 1);
    chk("t5_avg_l", avg_l, (7 * 500 + 300) / 8);

    // Reset asserted while the FSM is in UPD
    @(negedge CLK);
    CSLD  = 1'b0;
    num   = W'(555);
    right = 1'b0;
    repeat (3) @(negedge CLK);
    CSLD = 1'b1;
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    chk("t6_reset_outputs", {avg_l, avg_r, avg_valid, avg_ch, primed_l, primed_r, overrun}, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    hist_l.delete();
    hist_r.delete();
    repeat (4) @(negedge CLK);
    chk("t6_after_release", {avg_l, avg_r, avg_valid, primed_l, primed_r, overrun}, 0);
    send(1'b0, 800);
    chk("t6_avg_l", avg_l, 100);
    chk("t6_primed_l", primed_l, 0);

    // Randomized traffic on both channels
    for (int i = 0; i < 40; i++) begin
      send(1'($urandom_range(0, 1)), int'($urandom_range(0, 1023)));
    end
    chk("rand_overrun", overrun, 0);

    // Drain with a bounded wait
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge CLK);
    chk("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
